uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Buffered front-end for uart_tx. Accepts bytes from the host at up to one per clock.
//  Stores them in a FIFO and drains them one frame at a time into uart_tx (i_Tx_DV/i_Tx_Byte).
//  It paces on uart_tx's o_Tx_Active/o_Tx_Done, so that back-to-back host writes become back-to-back serial frames.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >=2
//  ADDR_W  4   log2(DEPTH); must match DEPTH
// PORTS
//  i_Clock     in   1         system clock; all logic on posedge
//  i_Reset     in   1         synchronous, active-high reset
//  i_Wr_DV     in   1         host write strobe, 1 cycle per byte
//  i_Wr_Byte   in   8         host data, sampled when i_Wr_DV=1
//  o_Full      out  1         count==DEPTH
//  o_Empty     out  1         count==0
//  o_Count     out  ADDR_W+1  entries currently stored
//  o_Overflow  out  1         1-cycle pulse: write dropped because full
//  o_Tx_DV     out  1         to uart_tx i_Tx_DV; 1-cycle launch pulse
//  o_Tx_Byte   out  8         to uart_tx i_Tx_Byte; valid while o_Tx_DV=1
//  i_Tx_Active in   1         from uart_tx o_Tx_Active
//  i_Tx_Done   in   1         from uart_tx o_Tx_Done (1-cycle pulse after stop bit)
// BEHAVIOUR
//  Reset (synchronous, held >=1 edge) sets the following:
//   - rd/wr pointers=0, o_Count=0, o_Empty=1, o_Full=0, o_Overflow=0.
//   - o_Tx_DV=0, o_Tx_Byte=8'h00, FSM=IDLE.
//   - FIFO contents are discarded, not cleared.
//  All outputs are registered. o_Full, o_Empty and o_Count update on the edge after a push/pop.
//  Write: i_Wr_DV=1 and !o_Full -> store at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//  Write when o_Full -> byte dropped, o_Overflow=1 next cycle only.
//   - This holds even if a pop occurs in the same cycle.
//  Pop: occurs only on the IDLE->LAUNCH transition; rd_ptr++ (wraps mod DEPTH).
//  Push+pop in the same cycle leaves count unchanged.
//  FSM:
//   IDLE   : if !o_Empty && !i_Tx_Active -> LAUNCH.
//            On that edge: o_Tx_Byte<=mem[rd_ptr], o_Tx_DV<=1, pop.
//   LAUNCH : o_Tx_DV<=0 -> WAIT_DONE (o_Tx_DV is high exactly one cycle).
//   WAIT_DONE: on i_Tx_Done -> GAP. i_Tx_Active is ignored here.
//   GAP    : one cycle -> IDLE. This covers uart_tx's cleanup state.
//  Latency: a byte written into an empty FIFO with the FSM IDLE and the line idle
//   sees o_Tx_DV=1 one cycle after the write edge (first-word data uses the registered count).
//  Ordering is strict FIFO. o_Tx_Byte holds its last value between launches.
//  Reset mid-frame: the FSM returns to IDLE, but uart_tx may still be sending.
//   - The IDLE guard on !i_Tx_Active blocks any launch until that frame ends.
//   - No o_Tx_DV is ever issued while i_Tx_Active=1.
//  i_Tx_Done outside WAIT_DONE is ignored.
//  o_Count never exceeds DEPTH and never underflows. Pop is gated by !o_Empty.
// STRUCTURE
//  uart_defs.vh (shared include) holds:
//   - FSM state localparams: IDLE=2'd0, LAUNCH=2'd1, WAIT_DONE=2'd2, GAP=2'd3.
//   - Default DEPTH/ADDR_W, reused by the rx side.
//  Sub-module sync_fifo (DEPTH, ADDR_W, WIDTH=8): mem, pointers, count, full/empty, overflow.
//  uart_tx_fifo = sync_fifo + launch FSM + output registers.
// TESTING  (bench instantiates uart_tx with CLKS_PER_BIT=2, 20 ns clock, DEPTH=4)
//  1 Reset: assert i_Reset 2 cycles -> o_Empty=1, o_Full=0, o_Count=0, o_Tx_DV=0, o_Overflow=0.
//  2 Single write 0xAB -> o_Tx_DV high exactly 1 cycle, 1 cycle later, with o_Tx_Byte=0xAB.
//    Serial line decodes 0xAB; o_Empty=1 afterwards.
//  3 Burst 0x11,0x22,0x33 on consecutive cycles -> three frames in order.
//    Each o_Tx_DV comes >=2 cycles after the previous i_Tx_Done; never while i_Tx_Active=1.
//  4 While frame 1 is active, write 5 more bytes -> o_Full=1 after the 4th.
//    o_Overflow pulses once on the 5th; the 5th byte is never transmitted.
//  5 Count=1, push on the same cycle as the launch pop -> o_Count stays 1; both bytes are sent in order.
//  6 i_Reset mid-frame with 3 queued -> queue flushed, o_Tx_DV=0.
//    A new write 0x56 launches only after i_Tx_Active falls; 0x56 is received correctly.

Source files
------------

// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and defaults for the buffered UART transmit front-end.
// Default FIFO sizing is also used by the receive side.
package uart_tx_fifo_pkg;

    localparam int unsigned DEFAULT_DEPTH  = 16;
    localparam int unsigned DEFAULT_ADDR_W = 4;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port, FIFO status and uart_tx launch/pacing handshake.
// The slave modport is the FIFO; the master modport is host plus uart_tx.
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) ();

    logic              i_Wr_DV;
    logic [BYTE_W-1:0] i_Wr_Byte;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_Tx_DV;
    logic [BYTE_W-1:0] o_Tx_Byte;
    logic              i_Tx_Active;
    logic              i_Tx_Done;

    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte
    );

    modport master (
        output i_Wr_DV, i_Wr_Byte, i_Tx_Active, i_Tx_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_Tx_DV, o_Tx_Byte
    );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and a one-cycle overflow flag.
// Storage is not reset; only pointers and status are.
module uart_tx_fifo_sync_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;
    logic [ADDR_W:0]   count_nxt;

    // A full FIFO drops the write even when a pop frees a slot this cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + (ADDR_W+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
            count    <= count_nxt;
            full     <= (count_nxt == (ADDR_W+1)'(DEPTH));
            empty    <= (count_nxt == '0);
            overflow <= push && full;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered uart_tx front-end: queues host bytes and launches one serial frame at a time,
// pacing on the transmitter's active/done handshake.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = DEFAULT_DEPTH,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic           i_Clock,
    input  logic           i_Reset,
    uart_tx_fifo_if.slave  bus
);

    tx_state_e         state;
    tx_state_e         state_nxt;
    logic              pop;
    logic [BYTE_W-1:0] head_byte;

    uart_tx_fifo_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (BYTE_W)
    ) u_fifo (
        .clk      (i_Clock),
        .rst      (i_Reset),
        .push     (bus.i_Wr_DV),
        .wr_data  (bus.i_Wr_Byte),
        .pop      (pop),
        .rd_data  (head_byte),
        .count    (bus.o_Count),
        .full     (bus.o_Full),
        .empty    (bus.o_Empty),
        .overflow (bus.o_Overflow)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // The active guard also holds off launches while a frame begun before reset drains.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.o_Empty && !bus.i_Tx_Active) begin
                    state_nxt = LAUNCH;
                    pop       = 1'b1;
                end
            end
            LAUNCH:    state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.i_Tx_Done) state_nxt = GAP;
            GAP:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            bus.o_Tx_DV   <= 1'b0;
            bus.o_Tx_Byte <= '0;
        end else begin
            bus.o_Tx_DV <= pop;
            if (pop) bus.o_Tx_Byte <= head_byte;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (DEPTH=4) driving a behavioural uart_tx (2 clocks per bit)
// and a serial decoder; launches and decoded bytes are scored against queues.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int          CPB    = 2;
    localparam int          BOUND  = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] ser_q[$];
    bit         gap_en = 1'b0;
    int         last_done = -100;
    int         rx_count = 0;
    int         ovf_cnt = 0;
    bit         rx_busy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Behavioural uart_tx: start, 8 data LSB first, stop; done pulses one cycle, then cleanup.
    int         m_state = 0;
    int         m_cnt = 0;
    int         m_idx = 0;
    logic [9:0] m_sh = '1;
    logic       tx_serial = 1'b1;
    logic       m_active = 1'b0;
    logic       m_done = 1'b0;
    assign bus.i_Tx_Active = m_active;
    assign bus.i_Tx_Done   = m_done;

    always @(posedge clk) begin
        case (m_state)
            0: begin
                if (bus.o_Tx_DV === 1'b1) begin
                    m_sh      <= {1'b1, bus.o_Tx_Byte, 1'b0};
                    m_idx     <= 0;
                    m_cnt     <= 0;
                    tx_serial <= 1'b0;
                    m_active  <= 1'b1;
                    m_state   <= 1;
                end
            end
            1: begin
                if (m_cnt == CPB - 1) begin
                    m_cnt <= 0;
                    if (m_idx == 9) begin
                        m_done   <= 1'b1;
                        m_active <= 1'b0;
                        m_state  <= 2;
                    end else begin
                        m_idx     <= m_idx + 1;
                        tx_serial <= m_sh[m_idx + 1];
                    end
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
            default: begin
                m_done  <= 1'b0;
                m_state <= 0;
            end
        endcase
    end

    // Launch monitor: byte order, pulse width, no launch while active, pacing after done.
    initial begin
        logic       prev_dv = 1'b0;
        logic [7:0] eb;
        bit         have;
        forever begin
            @(negedge clk);
            if (bus.o_Tx_DV === 1'b1) begin
                chk("launch_while_active", bus.i_Tx_Active, 0);
                chk("launch_pulse_width", prev_dv, 0);
                have = exp_q.size() != 0;
                chk("launch_expected", have, 1);
                if (have) begin
                    eb = exp_q.pop_front();
                    chk("launch_byte", bus.o_Tx_Byte, eb);
                    ser_q.push_back(eb);
                end
                if (gap_en) chk("launch_gap_after_done", (cyc - last_done) >= 2, 1);
            end
            if (bus.i_Tx_Done === 1'b1) last_done = cyc;
            if (bus.o_Overflow === 1'b1) ovf_cnt++;
            prev_dv = bus.o_Tx_DV;
        end
    end

    // Serial decoder sampling the second half of each 2-clock bit.
    initial begin
        int         rx_k = 0;
        logic [7:0] rx_sh = '0;
        logic [7:0] eb;
        bit         have;
        forever begin
            @(negedge clk);
            if (!rx_busy) begin
                if (tx_serial === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_k = 0;
                end
            end else begin
                rx_k++;
                if (rx_k >= 3 && rx_k <= 17 && (rx_k % 2) == 1) rx_sh[(rx_k - 3) / 2] = tx_serial;
                if (rx_k == 19) begin
                    rx_busy = 1'b0;
                    rx_count++;
                    chk("rx_stop_bit", tx_serial, 1);
                    have = ser_q.size() != 0;
                    chk("rx_expected", have, 1);
                    if (have) begin
                        eb = ser_q.pop_front();
                        chk("rx_byte", rx_sh, eb);
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit sent);
        @(negedge clk);
        bus.i_Wr_DV   = 1'b1;
        bus.i_Wr_Byte = b;
        if (sent) exp_q.push_back(b);
    endtask

    task automatic end_write();
        @(negedge clk);
        bus.i_Wr_DV = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || ser_q.size() != 0 || bus.i_Tx_Active || rx_busy) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_timeout"}, n < BOUND, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_active(input string tag);
        int n = 0;
        while (!bus.i_Tx_Active && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_active_timeout"}, n < 50, 1);
    endtask

    initial begin
        bus.i_Wr_DV   = 1'b0;
        bus.i_Wr_Byte = '0;

        // 1: reset held two edges
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_empty", bus.o_Empty, 1);
        chk("rst_full", bus.o_Full, 0);
        chk("rst_count", bus.o_Count, 0);
        chk("rst_tx_dv", bus.o_Tx_DV, 0);
        chk("rst_overflow", bus.o_Overflow, 0);

        // 2: single byte, launch one cycle after the write edge
        push_byte(8'hAB, 1'b1);
        end_write();
        chk("t2_count_after_write", bus.o_Count, 1);
        chk("t2_dv_not_yet", bus.o_Tx_DV, 0);
        @(negedge clk);
        chk("t2_dv_latency", bus.o_Tx_DV, 1);
        chk("t2_tx_byte", bus.o_Tx_Byte, 8'hAB);
        chk("t2_count_after_pop", bus.o_Count, 0);
        @(negedge clk);
        chk("t2_dv_low", bus.o_Tx_DV, 0);
        chk("t2_byte_held", bus.o_Tx_Byte, 8'hAB);
        wait_drain("t2");
        chk("t2_empty", bus.o_Empty, 1);
        chk("t2_rx_count", rx_count, 1);

        // 3: back-to-back burst becomes paced frames in order
        gap_en = 1'b1;
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        end_write();
        wait_drain("t3");
        gap_en = 1'b0;
        chk("t3_rx_count", rx_count, 4);
        chk("t3_empty", bus.o_Empty, 1);

        // 4: fill while frame 1 is on the line, fifth write overflows
        push_byte(8'hC1, 1'b1);
        end_write();
        wait_active("t4");
        push_byte(8'hC2, 1'b1);
        push_byte(8'hC3, 1'b1);
        push_byte(8'hC4, 1'b1);
        push_byte(8'hC5, 1'b1);
        push_byte(8'hC6, 1'b0);
        chk("t4_full", bus.o_Full, 1);
        chk("t4_count_full", bus.o_Count, DEPTH);
        chk("t4_no_overflow_yet", bus.o_Overflow, 0);
        end_write();
        chk("t4_overflow_pulse", bus.o_Overflow, 1);
        chk("t4_count_capped", bus.o_Count, DEPTH);
        @(negedge clk);
        chk("t4_overflow_cleared", bus.o_Overflow, 0);
        chk("t4_still_full", bus.o_Full, 1);
        wait_drain("t4");
        chk("t4_overflow_once", ovf_cnt, 1);
        chk("t4_rx_count", rx_count, 9);
        chk("t4_empty", bus.o_Empty, 1);

        // 5: push on the same edge as the launch pop
        push_byte(8'hD1, 1'b1);
        push_byte(8'hD2, 1'b1);
        end_write();
        chk("t5_dv_on_pop", bus.o_Tx_DV, 1);
        chk("t5_count_unchanged", bus.o_Count, 1);
        chk("t5_not_empty", bus.o_Empty, 0);
        wait_drain("t5");
        chk("t5_rx_count", rx_count, 11);

        // 6: reset mid-frame with three queued
        push_byte(8'hE0, 1'b1);
        push_byte(8'hE1, 1'b1);
        push_byte(8'hE2, 1'b1);
        push_byte(8'hE3, 1'b1);
        end_write();
        chk("t6_count_queued", bus.o_Count, 3);
        chk("t6_line_active", bus.i_Tx_Active, 1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("t6_flush_count", bus.o_Count, 0);
        chk("t6_flush_empty", bus.o_Empty, 1);
        chk("t6_flush_tx_dv", bus.o_Tx_DV, 0);
        chk("t6_frame_still_active", bus.i_Tx_Active, 1);
        push_byte(8'h56, 1'b1);
        end_write();
        chk("t6_held_off", bus.o_Tx_DV, 0);
        wait_drain("t6");
        chk("t6_rx_count", rx_count, 13);
        chk("t6_final_empty", bus.o_Empty, 1);
        chk("t6_overflow_total", ovf_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
